mult_scheduler: RTL and testbench
=================================

Name: mult_scheduler

Overview:
- Shares one iterative shift-add multiplier between the two execution lanes of the dual-issue pipeline.
- Sequences back-to-back multiplies when both lanes request in the same cycle, in program order: lane 1 is older.
- Owns the architectural HI/LO registers.
- Generates the single multiply stall that freezes both execution-stage buffers and everything upstream.

Parameters:
- width, 32: operand width. Product is 2*width; HI = upper width bits, LO = lower width bits.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- req_1  in  1  lane 1 E-stage instruction is a multiply
- req_2  in  1  lane 2 E-stage instruction is a multiply
- sign_1  in  1  lane 1 multiply is signed
- sign_2  in  1  lane 2 multiply is signed
- srcA_1, srcB_1  in  width  lane 1 forwarded operands
- srcA_2, srcB_2  in  width  lane 2 forwarded operands
- stall_ext  in  1  E stage held by another hazard source
- flush_E  in  1  kill E-stage contents
- multStall  out  1  hold E stage and upstream stages
- hi, lo  out  width  architectural HI/LO; feed lo_E_t/hi_E_t of both lanes
- busy_lane  out  2  one-hot lane being computed; 00 when not computing

Behaviour:
- Reset:
  - state=IDLE, hi=lo=0, multStall=0, busy_lane=00, counter=0.
- States: IDLE, BUSY1, BUSY2, DONE.
- IDLE:
  - req_1 → load lane 1 operands; go to BUSY1.
  - req_2 only → load lane 2 operands; go to BUSY2.
  - Pending flag both=req_1&req_2 is latched at this edge.
- BUSY1 / BUSY2:
  - Exactly width cycles, one shift-add step per cycle; counter runs 0..width-1.
  - On the last step, the product is written to {hi,lo} at that edge.
  - BUSY1 then goes to BUSY2 if both is set (lane 2 operands sampled at that edge; inputs are held stable by the stall), else to DONE.
  - BUSY2 goes to DONE.
- DONE:
  - multStall=0, so the pipeline advances.
  - If stall_ext=1, remain in DONE; this prevents re-issuing the same held instruction. Otherwise go to IDLE.
- multStall (combinational) = (IDLE & (req_1|req_2) & ~flush_E) | BUSY1 | BUSY2.
- Latency:
  - Single multiply: stall high 1+width cycles (33). HI/LO valid in the DONE cycle.
  - Dual multiply: stall high 1+2*width cycles (65). HI/LO end with lane 2's product; lane 1's product is briefly visible during BUSY2, and no consumer reads it because the pipeline is stalled.
- Arithmetic:
  - Unsigned: plain radix-2 shift-add on 2*width bits.
  - Signed: operate on magnitudes; negate the product if the operand signs differ.
  - Most-negative operand (0x80000000) handled via width+1-bit magnitude.
- flush_E in any state:
  - Go to IDLE next edge, clear both.
  - hi/lo are NOT updated if flush hits on the last step (flush has priority).
- reset mid-operation: same as the reset values above; the product is discarded.
- req seen in DONE: ignored; it is the same instruction still held.
- Simultaneous stall_ext and completion: the write still happens and the FSM waits in DONE.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, BUSY1=2'd1, BUSY2=2'd2, DONE=2'd3) and the lane one-hot constants.
- Sub-module mult_core: one shift-add datapath with load, step, and a done-on-last-step strobe. Contains sign handling and the final negation. The scheduler owns arbitration, HI/LO and stall.

Test Plan:
- Reset with reset=1 for 2 cycles, no requests → hi=lo=0, multStall=0, busy_lane=00.
- req_1 only, unsigned 0xFFFFFFFF×2 → stall exactly 33 cycles; then hi=0x00000001, lo=0xFFFFFFFE; state DONE for 1 cycle.
- req_1 and req_2 together: lane1 signed -3×7, lane2 unsigned 5×6 → stall 65 cycles; after BUSY1 hi=0xFFFFFFFF, lo=0xFFFFFFEB; final hi=0, lo=30.
- Signed 0x80000000×0x80000000 → hi=0x40000000, lo=0.
- flush_E pulse at cycle 10 of BUSY1 → next cycle IDLE, multStall=0, hi/lo keep prior values.
- stall_ext=1 held for 3 cycles at completion → stays in DONE, no second multiply started.
- After stall_ext drops → IDLE; a new req_2 the following cycle starts a fresh 33-cycle stall.

Source files
------------

// File: rtl/mult_scheduler_pkg.sv
// Shared definitions for the dual-lane multiply scheduler: FSM encoding and lane one-hot codes.
package mult_scheduler_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY1 = 2'd1,
      BUSY2 = 2'd2,
      DONE  = 2'd3
   } stateT;

   localparam logic [1:0] LANE_NONE = 2'b00;
   localparam logic [1:0] LANE_1    = 2'b01;
   localparam logic [1:0] LANE_2    = 2'b10;

   // One-hot lane under computation for a given scheduler state.
   function automatic logic [1:0] laneOf(input stateT s);
      case (s)
         BUSY1:   laneOf = LANE_1;
         BUSY2:   laneOf = LANE_2;
         default: laneOf = LANE_NONE;
      endcase
   endfunction

endpackage

// File: rtl/mult_core.sv
// Radix-2 shift-add multiplier: one step per cycle for width cycles, signed via magnitudes
// with a final conditional negation.
module mult_core #(
   parameter int unsigned width = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic                 step,
   input  logic                 signedOp,
   input  logic [width-1:0]     opA,
   input  logic [width-1:0]     opB,
   output logic                 lastCount_c,
   output logic                 done_c,
   output logic [2*width-1:0]   product_c
);

   localparam int unsigned CW = (width > 1) ? $clog2(width) : 1;
   localparam int unsigned PW = 2 * width;

   logic [width:0]   extA, extB, magA, magB;
   logic [PW-1:0]    acc, mcand, accNext;
   logic [width:0]   mplier;
   logic             negate;
   logic [CW-1:0]    count;

   // width+1-bit magnitudes keep the most-negative operand representable.
   assign extA = {signedOp & opA[width-1], opA};
   assign extB = {signedOp & opB[width-1], opB};
   assign magA = extA[width] ? (~extA + 1'b1) : extA;
   assign magB = extB[width] ? (~extB + 1'b1) : extB;

   assign accNext     = acc + (mplier[0] ? mcand : '0);
   assign product_c   = negate ? (~accNext + 1'b1) : accNext;
   assign lastCount_c = (count == CW'(width - 1));
   assign done_c      = step & lastCount_c;

   always_ff @(posedge clk) begin
      if (reset) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         negate <= 1'b0;
         count  <= '0;
      end else if (load) begin
         acc    <= '0;
         mcand  <= PW'(magA);
         mplier <= magB;
         negate <= signedOp & (opA[width-1] ^ opB[width-1]);
         count  <= '0;
      end else if (step) begin
         acc    <= accNext;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count + 1'b1;
      end
   end

endmodule

// File: rtl/mult_scheduler.sv
// Shares one iterative multiplier between two issue lanes, owns HI/LO and raises the
// multiply stall; lane 1 is older and is always computed first.
module mult_scheduler
   import mult_scheduler_pkg::*;
#(
   parameter int unsigned width = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_1,
   input  logic               req_2,
   input  logic               sign_1,
   input  logic               sign_2,
   input  logic [width-1:0]   srcA_1,
   input  logic [width-1:0]   srcB_1,
   input  logic [width-1:0]   srcA_2,
   input  logic [width-1:0]   srcB_2,
   input  logic               stall_ext,
   input  logic               flush_E,
   output logic               multStall,
   output logic [width-1:0]   hi,
   output logic [width-1:0]   lo,
   output logic [1:0]         busy_lane
);

   stateT               state, stateNext;
   logic                both, bothNext;
   logic                coreLoad, coreStep, useLane2;
   logic                lastCount, coreDone;
   logic [2*width-1:0]  product;

   mult_core #(.width(width)) u_core (
      .clk         (clk),
      .reset       (reset),
      .load        (coreLoad),
      .step        (coreStep),
      .signedOp    (useLane2 ? sign_2 : sign_1),
      .opA         (useLane2 ? srcA_2 : srcA_1),
      .opB         (useLane2 ? srcB_2 : srcB_1),
      .lastCount_c (lastCount),
      .done_c      (coreDone),
      .product_c   (product)
   );

   // Next-state, core control and stall.
   always_comb begin
      stateNext = state;
      bothNext  = both;
      coreLoad  = 1'b0;
      coreStep  = 1'b0;
      useLane2  = 1'b0;
      multStall = 1'b0;
      case (state)
         IDLE: begin
            if (req_1 | req_2) begin
               multStall = ~flush_E;
               coreLoad  = 1'b1;
               useLane2  = ~req_1;
               bothNext  = req_1 & req_2;
               stateNext = req_1 ? BUSY1 : BUSY2;
            end
         end
         BUSY1: begin
            multStall = 1'b1;
            coreStep  = 1'b1;
            if (lastCount) begin
               if (both) begin
                  coreLoad  = 1'b1;
                  useLane2  = 1'b1;
                  stateNext = BUSY2;
               end else begin
                  stateNext = DONE;
               end
            end
         end
         BUSY2: begin
            multStall = 1'b1;
            coreStep  = 1'b1;
            if (lastCount) begin
               bothNext  = 1'b0;
               stateNext = DONE;
            end
         end
         DONE: begin
            // Held instruction is still in E; waiting here keeps it from re-issuing.
            if (!stall_ext) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
      if (flush_E) begin
         stateNext = IDLE;
         bothNext  = 1'b0;
         coreLoad  = 1'b0;
         coreStep  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         both      <= 1'b0;
         hi        <= '0;
         lo        <= '0;
         busy_lane <= LANE_NONE;
      end else begin
         state     <= stateNext;
         both      <= bothNext;
         busy_lane <= laneOf(stateNext);
         if (coreDone) {hi, lo} <= product;
      end
   end

endmodule

// File: tb/tb_mult_scheduler.sv
// Randomized scoreboard bench for mult_scheduler: stimulus queues expected HI/LO and stall
// lengths from plain 64-bit arithmetic; a negedge monitor checks each completion.
module tb_mult_scheduler;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_1 = 1'b0, req_2 = 1'b0, sign_1 = 1'b0, sign_2 = 1'b0;
   logic [31:0] srcA_1 = '0, srcB_1 = '0, srcA_2 = '0, srcB_2 = '0;
   logic        stall_ext = 1'b0, flush_E = 1'b0;
   logic        multStall;
   logic [31:0] hi, lo;
   logic [1:0]  busy_lane;

   typedef struct {
      logic [63:0] prod;
      int          len;
   } expT;

   expT         finalQ[$];
   logic [63:0] interQ[$];
   logic [63:0] mProd = '0;
   int          total = 0;
   int          passed = 0;
   bit          monOn = 1'b0;
   bit          prevStall = 1'b0;
   logic [1:0]  prevBusy = 2'b00;
   int          stallCnt = 0;

   mult_scheduler #(.width(32)) dut (
      .clk(clk), .reset(reset), .req_1(req_1), .req_2(req_2),
      .sign_1(sign_1), .sign_2(sign_2),
      .srcA_1(srcA_1), .srcB_1(srcB_1), .srcA_2(srcA_2), .srcB_2(srcB_2),
      .stall_ext(stall_ext), .flush_E(flush_E),
      .multStall(multStall), .hi(hi), .lo(lo), .busy_lane(busy_lane)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else passed++;
   endtask

   function automatic logic [63:0] refMul(input bit s, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb;
      logic [63:0] ua, ub;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      ua = 64'(a);
      ub = 64'(b);
      return ua * ub;
   endfunction

   function automatic logic [31:0] randOp();
      case ($urandom_range(0, 5))
         0:       return 32'h8000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h0;
         default: return $urandom;
      endcase
   endfunction

   // Completion monitor: every falling edge of the stall consumes one expected result.
   always @(negedge clk) begin
      if (monOn) begin
         if (multStall) begin
            stallCnt++;
         end else if (prevStall) begin
            if (finalQ.size() == 0) begin
               total++;
               $display("FAIL unexpected_completion: got hi=%h lo=%h expected none", hi, lo);
            end else begin
               expT e;
               e = finalQ.pop_front();
               check("final_hilo", {hi, lo}, e.prod);
               if (e.len >= 0) check("stall_len", 64'(stallCnt), 64'(e.len));
            end
            stallCnt = 0;
         end
         if (prevBusy == 2'b01 && busy_lane == 2'b10) begin
            if (interQ.size() == 0) begin
               total++;
               $display("FAIL unexpected_lane_switch: got busy_lane=%b expected none", busy_lane);
            end else begin
               check("lane1_hilo", {hi, lo}, interQ.pop_front());
            end
         end
         if (!multStall) check("idle_busy_lane", 64'(busy_lane), 64'(0));
      end
      prevStall = multStall;
      prevBusy  = busy_lane;
   end

   task automatic doMult(input bit r1, input bit r2, input bit s1, input bit s2,
                         input logic [31:0] a1, input logic [31:0] b1,
                         input logic [31:0] a2, input logic [31:0] b2, input int hold);
      logic [63:0] p1, p2;
      expT         e;
      int          cnt;
      p1 = refMul(s1, a1, b1);
      p2 = refMul(s2, a2, b2);
      if (r1 && r2) begin
         interQ.push_back(p1);
         e.prod = p2;
         e.len  = 65;
      end else begin
         e.prod = r1 ? p1 : p2;
         e.len  = 33;
      end
      finalQ.push_back(e);
      mProd = e.prod;
      @(posedge clk); #1;
      req_1 = r1; req_2 = r2; sign_1 = s1; sign_2 = s2;
      srcA_1 = a1; srcB_1 = b1; srcA_2 = a2; srcB_2 = b2;
      stall_ext = (hold > 0);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (multStall && cnt < 200);
      if (cnt >= 200) begin
         total++;
         $display("FAIL done_timeout: got stall after %0d cycles expected completion", cnt);
      end
      // Request stays asserted while DONE is held: it must not start a second multiply.
      for (int i = 1; i < hold; i++) begin
         @(negedge clk);
         check("hold_stall", 64'(multStall), 64'(0));
         check("hold_hilo", {hi, lo}, mProd);
      end
      req_1 = 1'b0; req_2 = 1'b0; stall_ext = 1'b0;
   endtask

   task automatic doFlush(input int atCount);
      expT e;
      e.prod = mProd;
      e.len  = atCount + 2;
      finalQ.push_back(e);
      @(posedge clk); #1;
      req_1 = 1'b1; sign_1 = 1'($urandom); srcA_1 = randOp(); srcB_1 = randOp() | 32'h1;
      repeat (atCount + 1) @(posedge clk);
      #1 flush_E = 1'b1; req_1 = 1'b0;
      @(posedge clk); #1 flush_E = 1'b0;
      @(negedge clk);
      check("flush_stall", 64'(multStall), 64'(0));
      check("flush_hilo_kept", {hi, lo}, mProd);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish expected end of test");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_hi", 64'(hi), 64'(0));
      check("rst_lo", 64'(lo), 64'(0));
      check("rst_stall", 64'(multStall), 64'(0));
      check("rst_busy", 64'(busy_lane), 64'(0));
      monOn = 1'b1;

      doMult(1, 0, 0, 0, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0, 0);
      check("ffff_x2", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
      doMult(1, 1, 1, 0, 32'hFFFF_FFFD, 32'h7, 32'h5, 32'h6, 0);
      check("dual_final", {hi, lo}, 64'd30);
      doMult(1, 0, 1, 0, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0, 0);
      check("most_neg_sq", {hi, lo}, 64'h4000_0000_0000_0000);
      doFlush(10);
      doFlush(31);
      doMult(0, 1, 0, 0, randOp(), randOp(), 32'h1234_5678, 32'h9ABC_DEF0, 3);
      doMult(0, 1, 1, 1, randOp(), randOp(), randOp(), randOp(), 0);

      for (int n = 0; n < 12; n++) begin
         bit r1, r2;
         r1 = 1'($urandom);
         r2 = r1 ? 1'($urandom) : 1'b1;
         doMult(r1, r2, 1'($urandom), 1'($urandom), randOp(), randOp(), randOp(), randOp(),
                ($urandom_range(0, 3) == 0) ? 2 : 0);
      end

      // Reset in the middle of a multiply discards the product.
      begin
         expT e;
         e.prod = 64'd0;
         e.len  = -1;
         finalQ.push_back(e);
         mProd = '0;
         @(posedge clk); #1;
         req_1 = 1'b1; sign_1 = 1'b0; srcA_1 = 32'hDEAD_BEEF; srcB_1 = 32'h3;
         repeat (5) @(posedge clk);
         #1 reset = 1'b1; req_1 = 1'b0;
         @(posedge clk); #1 reset = 1'b0;
         @(negedge clk);
         check("midrst_hilo", {hi, lo}, 64'd0);
         check("midrst_busy", 64'(busy_lane), 64'(0));
      end

      repeat (3) @(negedge clk);
      check("final_queue_empty", 64'(finalQ.size()), 64'(0));
      check("lane1_queue_empty", 64'(interQ.size()), 64'(0));
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
